// File: rtl/par_scrambler.sv
`default_nettype none
// ============================================================================
// Module      : par_scrambler
// Description : Multi-lane, multi-bit-per-cycle multiplicative scrambler or
//               descrambler (MODE). One LFSR per lane, WIDTH bits unrolled
//               per beat, valid/ready handshake with a one-beat output
//               register, in-band resync and optional periodic auto-reseed.
//               Optional feature macro: SCR_BYPASS_EN adds a 'bypass' input
//               that passes data through while the LFSRs keep advancing.
// Revision    : 1.0 - initial release
// ============================================================================
module par_scrambler #(
  parameter int                  LFSR_LEN      = 24,
  parameter logic [LFSR_LEN-1:0] POLY          = 24'hA10124,
  parameter logic [LFSR_LEN-1:0] SEED          = 24'h1FEEDD,
  parameter int                  WIDTH         = 8,
  parameter int                  LANES         = 2,
  parameter int                  MODE          = 0,
  parameter int                  RESEED_PERIOD = 0
) (
  input  logic                   clk,
  input  logic                   rst,        // asynchronous, active low
  input  logic                   enable,
`ifdef SCR_BYPASS_EN
  input  logic                   bypass,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_sync,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_sync,
  output logic [15:0]            beat_cnt
);

  // Beat count that triggers an automatic reseed (unused when period is 0).
  localparam logic [15:0] RESEED_CMP = 16'(RESEED_PERIOD);

  // Lane l starts from the base seed with the lane index folded in, so the
  // lanes never run identical sequences.
  function automatic logic [LFSR_LEN-1:0] lane_seed(input int l);
    return SEED ^ LFSR_LEN'(l);
  endfunction

  logic [LANES-1:0][LFSR_LEN-1:0] lfsr_q, lfsr_d;
  logic [LANES-1:0][LFSR_LEN-1:0] lfsr_adv;
  logic [LANES*WIDTH-1:0]         proc_data;
  logic [LANES*WIDTH-1:0]         out_src;
  logic [LANES*WIDTH-1:0]         out_data_q, out_data_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_sync_q, out_sync_d;
  logic [15:0]                    beat_cnt_q, beat_cnt_d;
  logic [15:0]                    cnt_inc;
  logic                           accept;
  logic                           auto_hit;
  logic                           reseed;

  assign in_ready  = enable && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sync  = out_sync_q;
  assign beat_cnt  = beat_cnt_q;

  // Saturating increment; a reseed (manual or automatic) is a single event
  // even when both causes coincide on the same beat.
  assign cnt_inc  = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
  assign auto_hit = (RESEED_PERIOD != 0) && (cnt_inc == RESEED_CMP);
  assign reseed   = in_sync || auto_hit;

  // Unrolled per-bit LFSR walk for every lane; bit 0 is oldest in time and
  // the scrambled-domain bit is always the one shifted into the register.
  always_comb begin
    logic [LFSR_LEN-1:0] st;
    logic                d;
    logic                t;
    logic                o;
    lfsr_adv  = lfsr_q;
    proc_data = '0;
    st        = '0;
    d         = 1'b0;
    t         = 1'b0;
    o         = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      st = lfsr_q[l];
      for (int b = 0; b < WIDTH; b++) begin
        d = in_data[l*WIDTH+b];
        t = ^(st & POLY);
        o = d ^ t;
        proc_data[l*WIDTH+b] = o;
        st = {st[LFSR_LEN-2:0], (MODE == 0) ? o : d};
      end
      lfsr_adv[l] = st;
    end
  end

`ifdef SCR_BYPASS_EN
  assign out_src = bypass ? in_data : proc_data;
`else
  assign out_src = proc_data;
`endif

  // Next-state selection: disable flushes everything, an accepted beat loads
  // the output register, otherwise a consumed beat just drops out_valid.
  always_comb begin
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sync_d  = out_sync_q;
    beat_cnt_d  = beat_cnt_q;
    if (!enable) begin
      for (int l = 0; l < LANES; l++) begin
        lfsr_d[l] = lane_seed(l);
      end
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_sync_d  = 1'b0;
      beat_cnt_d  = 16'd0;
    end else if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        lfsr_d[l] = reseed ? lane_seed(l) : lfsr_adv[l];
      end
      out_valid_d = 1'b1;
      out_data_d  = out_src;
      out_sync_d  = reseed;
      beat_cnt_d  = reseed ? 16'd0 : cnt_inc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear to the seed state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++) begin
        lfsr_q[l] <= lane_seed(l);
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sync_q  <= 1'b0;
      beat_cnt_q  <= 16'd0;
    end else begin
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sync_q  <= out_sync_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/par_scrambler.md
# par_scrambler

Parametrised multi-lane, multi-bit-per-cycle multiplicative scrambler/descrambler for the USB4 logical-layer datapath. It replaces the single-bit serial scrambler: it processes WIDTH bits per lane per cycle across LANES independent LFSRs. It has a valid/ready handshake with a one-beat output register, in-band resync, and an optional periodic auto-reseed counter. The same RTL, selected by MODE, is used on the TX (scramble) and RX (descramble) paths.

## Interface
- LFSR_LEN, 24: LFSR length in bits; register indexed [LFSR_LEN-1:0].
- POLY, 24'hA10124: tap mask. Bit k set means lfsr[k] feeds back. The default is taps 23, 21, 16, 8, 5, 2.
- SEED, 24'h1FEEDD: base seed. Lane l loads SEED ^ l.
- WIDTH, 8: bits per lane per beat, 1..32.
- LANES, 2: number of lanes, 1..4.
- MODE, 0: 0 = scramble, 1 = descramble.
- RESEED_PERIOD, 0: number of accepted beats between automatic reseeds. 0 disables the counter.
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  block enable. Low holds all LFSRs at seed and flushes the output.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*WIDTH  lane l occupies [l*WIDTH +: WIDTH]. Bit 0 of each lane is first in time.
- in_sync  in  1  resync request, qualified with the accepted beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*WIDTH  processed beat.
- out_sync  out  1  in_sync of the beat, or auto-reseed marker, aligned with out_data.
- beat_cnt  out  16  accepted beats since last reseed; saturates at 16'hFFFF.

## Operation
- Per bit b of each lane, processed in order 0..WIDTH-1 within a single cycle (combinational unroll):
  - t = XOR of lfsr[k] for each k set in POLY.
  - Scramble: o = d ^ t, then lfsr <= {lfsr[LFSR_LEN-2:0], o}.
  - Descramble: o = d ^ t, then lfsr <= {lfsr[LFSR_LEN-2:0], d}.
  - The scrambled bit is always what gets shifted in.
- LFSRs advance only on an accepted beat (in_valid && in_ready && enable).
- Resync:
  - An accepted beat with in_sync=1 is processed with the current LFSR state.
  - After that beat, every lane loads its seed and beat_cnt clears to 0.
- Auto-reseed (RESEED_PERIOD>0):
  - When an accepted beat brings beat_cnt to RESEED_PERIOD, that beat is processed normally.
  - The LFSRs then reseed, beat_cnt clears, and the beat's out_sync is 1.
  - in_sync on the same beat gives the same result; it is a single reseed, not a double one.
- Handshake:
  - in_ready = enable && (!out_valid || out_ready).
  - The output register loads on accept.
  - out_valid clears when out_ready is high and no new beat is accepted.
  - out_data and out_sync are stable while out_valid && !out_ready.
- enable low:
  - Next edge: LFSRs load seed, out_valid=0, out_data=0, out_sync=0, beat_cnt=0.
  - in_ready=0 combinationally.
  - A stalled output beat is discarded.
- Reset (async, rst=0): LFSRs load seed; out_valid=0, out_data=0, out_sync=0, beat_cnt=0. in_ready=0 until enable=1.

## Timing
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N. This is 1 cycle.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous drain and accept in the same cycle: the output register loads the new beat, so out_valid stays 1.
- Reset asserted mid-stream: all state is cleared immediately and asynchronously. The first beat after release uses the seed.
- The unrolled WIDTH-step XOR network is the critical path. WIDTH=32, LANES=4 must close timing at the datapath clock without an internal pipeline.

## Configuration
- SCR_BYPASS_EN: when defined, adds input port bypass (1 bit).
  - With bypass=1, out_data = in_data while LFSRs advance exactly as in normal operation, so the stream stays in sync when bypass drops.
  - bypass is sampled with the accepted beat.
- Undefined: no bypass port; behaviour is identical to bypass=0.

## Test plan
- Single-bit seed check. WIDTH=1, LANES=1, MODE=0, reset, enable=1, in_data=0 for one beat -> out_data=0 and internal lfsr=24'h3FDDBA after the beat.
- Round trip. MODE=0 instance chained to MODE=1 instance, WIDTH=8, LANES=2, 1000 random beats with random out_ready stalls -> descrambled output equals the source beat-for-beat, zero mismatches.
- Resync. in_sync=1 on beat 5 -> beat 6 output equals the beat-0 output for identical data (0x00), and beat_cnt=1 after beat 6.
- Auto-reseed. RESEED_PERIOD=4, continuous beats:
  - out_sync=1 on beats 3, 7 and 11.
  - beat_cnt cycles through 1, 2, 3, 0.
  - Same beat with in_sync=1 gives the same behaviour, a single reseed.
- Backpressure and enable. Hold out_ready=0 for 3 cycles -> in_ready=0 and out_data stable. Deassert enable during the stall -> out_valid=0 next cycle, and the next output after re-enable matches the seed output.
- Reset mid-stream. Assert rst=0 between clock edges during traffic -> out_valid, out_data and beat_cnt go to 0 immediately. After release, the first output equals the seed-derived value.
